pu_mac_engine: RTL



---
 rtl/pu_pkg.sv | 32 +++
 rtl/pu_mac_engine_if.sv | 28 ++
 rtl/pu_lane_mult.sv | 21 ++
 rtl/pu_mac_engine.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pu_pkg.sv
// Shared types and helpers for the pu_mac_engine neuron processing unit.
// Holds the FSM encoding, leaky-ReLU shift, sign-magnitude conversion and ACC_W legality check.
package pu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_BIAS  = 3'd3,
        ST_OUT   = 3'd4
    } pu_state_e;

    localparam int LEAKY_SHIFT = 3;

    // Sign-magnitude value of width dw (sign at bit dw-1) to 64-bit two's complement.
    function automatic logic signed [63:0] sm_to_tc(input logic [63:0] sm, input int dw);
        logic [63:0] mag;
        logic        neg;
        mag = sm & ((64'd1 << (dw - 1)) - 64'd1);
        neg = |(sm & (64'd1 << (dw - 1)));
        if (neg) begin
            sm_to_tc = -$signed(mag);
        end else begin
            sm_to_tc = $signed(mag);
        end
    endfunction

    function automatic bit acc_w_legal(input int acc_w, input int dw, input int lanes, input int rnd_w);
        return acc_w >= (2 * dw + $clog2(lanes) + rnd_w);
    endfunction

endpackage

// File: rtl/pu_mac_engine_if.sv
// Start/stream/result handshake bundle between the MLP controller and pu_mac_engine.
interface pu_mac_engine_if #(
    parameter int LANES = 8,
    parameter int DW    = 8,
    parameter int RND_W = 4
);
    logic                  start;
    logic [RND_W-1:0]      num_rounds;
    logic [DW-1:0]         bias;
    logic                  in_valid;
    logic                  in_ready;
    logic [LANES*DW-1:0]   in_data;
    logic [LANES*DW-1:0]   in_weight;
    logic                  out_valid;
    logic                  out_ready;
    logic [DW-1:0]         out_data;
    logic                  busy;

    modport master (
        output start, num_rounds, bias, in_valid, in_data, in_weight, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  start, num_rounds, bias, in_valid, in_data, in_weight, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/pu_lane_mult.sv
// One sign-magnitude DW x DW multiplier lane producing an ACC_W two's-complement product.
module pu_lane_mult
    import pu_pkg::*;
#(
    parameter int DW    = 8,
    parameter int ACC_W = 24
) (
    input  logic [DW-1:0]    a,
    input  logic [DW-1:0]    w,
    output logic [ACC_W-1:0] prod
);
    logic [2*DW-3:0] mag_s;
    logic            sign_s;

    // Magnitude product with XOR sign; a zero magnitude converts to 0 whatever its sign.
    always_comb begin
        mag_s  = (2*DW-2)'(a[DW-2:0]) * (2*DW-2)'(w[DW-2:0]);
        sign_s = a[DW-1] ^ w[DW-1];
        prod   = ACC_W'(sm_to_tc(64'({sign_s, mag_s}), 2*DW-1));
    end
endmodule

// File: rtl/pu_mac_engine.sv
// Neuron MAC engine: streams LANES products per beat, adds scaled bias, applies saturating activation.
// Optional macro PU_MAC_LEAKY_RELU_EN selects a leaky ReLU for negative pre-activations.
module pu_mac_engine
    import pu_pkg::*;
#(
    parameter int LANES     = 8,
    parameter int DW        = 8,
    parameter int RND_W     = 4,
    parameter int ACC_W     = 24,
    parameter int OUT_SHIFT = 9
) (
    input  logic           clk,
    input  logic           rst,
    pu_mac_engine_if.slave bus
);
    localparam bit                       ACC_W_OK   = acc_w_legal(ACC_W, DW, LANES, RND_W);
    localparam logic [DW-2:0]            MAG_MAX    = '1;
    localparam logic signed [ACC_W-1:0]  S_MAX      = ACC_W'((1 << (DW - 1)) - 1);
    localparam logic signed [63:0]       BIAS_SCALE = 64'((1 << (DW - 1)) - 1);

    if (!ACC_W_OK) begin : g_acc_w_check
        $fatal(1, "pu_mac_engine: ACC_W too narrow for DW/LANES/RND_W");
    end

    pu_state_e          state_r;
    pu_state_e          state_next_s;
    logic [RND_W-1:0]   num_rounds_r;
    logic [RND_W-1:0]   rnd_cnt_r;
    logic [DW-1:0]      bias_r;
    logic [ACC_W-1:0]   acc_r;
    logic [ACC_W-1:0]   prod_r [LANES];
    logic [ACC_W-1:0]   prod_s [LANES];
    logic               prod_vld_r;
    logic [ACC_W-1:0]   tree_sum_s;
    logic [ACC_W-1:0]   bias_term_s;
    logic [ACC_W-1:0]   acc_bias_s;
    logic               accept_s;
    logic               last_beat_s;
    logic               start_s;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               busy_r;
    logic [DW-1:0]      out_data_r;
    logic               in_ready_s;
    logic               out_valid_s;
    logic               busy_s;

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.busy      = busy_r;

    // Arithmetic shift, then ReLU (or leaky ReLU) saturated to DW-1 magnitude bits.
    function automatic logic [DW-1:0] activate(input logic [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] s;
`ifdef PU_MAC_LEAKY_RELU_EN
        logic signed [ACC_W-1:0] mag;
`endif
        s = $signed(acc) >>> OUT_SHIFT;
        if (s < 0) begin
`ifdef PU_MAC_LEAKY_RELU_EN
            mag = (-s) >>> LEAKY_SHIFT;
            if (mag == '0) begin
                activate = '0;
            end else if (mag > S_MAX) begin
                activate = {1'b1, MAG_MAX};
            end else begin
                activate = {1'b1, mag[DW-2:0]};
            end
`else
            activate = '0;
`endif
        end else if (s > S_MAX) begin
            activate = {1'b0, MAG_MAX};
        end else begin
            activate = {1'b0, s[DW-2:0]};
        end
    endfunction

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        pu_lane_mult #(
            .DW    (DW),
            .ACC_W (ACC_W)
        ) u_mult (
            .a    (bus.in_data[i*DW +: DW]),
            .w    (bus.in_weight[i*DW +: DW]),
            .prod (prod_s[i])
        );
    end

    // Handshake qualifiers and the bias contribution for the BIAS step.
    always_comb begin
        start_s     = (state_r == ST_IDLE) && bus.start;
        accept_s    = (state_r == ST_RUN) && bus.in_valid && in_ready_r;
        last_beat_s = ((RND_W+1)'(rnd_cnt_r) + (RND_W+1)'(1)) == (RND_W+1)'(num_rounds_r);
        bias_term_s = ACC_W'(sm_to_tc(64'(bias_r), DW) * BIAS_SCALE);
        acc_bias_s  = acc_r + bias_term_s;
    end

    // Adder tree over the registered lane products.
    always_comb begin
        tree_sum_s = '0;
        for (int i = 0; i < LANES; i++) begin
            tree_sum_s = tree_sum_s + prod_r[i];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next_s = (bus.num_rounds == '0) ? ST_DRAIN : ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (accept_s && last_beat_s) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DRAIN: state_next_s = ST_BIAS;
            ST_BIAS:  state_next_s = ST_OUT;
            ST_OUT: begin
                if (bus.out_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_OUT;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM outputs, decoded from the next state so the flops below track the state register.
    always_comb begin
        in_ready_s  = (state_next_s == ST_RUN);
        out_valid_s = (state_next_s == ST_OUT);
        busy_s      = (state_next_s != ST_IDLE);
    end

    // Per-neuron configuration latched at start, plus the accepted-beat counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            num_rounds_r <= '0;
            bias_r       <= '0;
            rnd_cnt_r    <= '0;
        end else if (start_s) begin
            num_rounds_r <= bus.num_rounds;
            bias_r       <= bus.bias;
            rnd_cnt_r    <= '0;
        end else if (accept_s) begin
            rnd_cnt_r    <= rnd_cnt_r + RND_W'(1);
        end
    end

    // Stage 1: register lane products on each accepted beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_vld_r <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                prod_r[i] <= '0;
            end
        end else begin
            prod_vld_r <= accept_s;
            if (accept_s) begin
                for (int i = 0; i < LANES; i++) begin
                    prod_r[i] <= prod_s[i];
                end
            end
        end
    end

    // Stage 2: accumulate the tree sum a cycle after acceptance; bias is added once in BIAS.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_r <= '0;
        end else if (start_s) begin
            acc_r <= '0;
        end else if (prod_vld_r) begin
            acc_r <= acc_r + tree_sum_s;
        end else if (state_r == ST_BIAS) begin
            acc_r <= acc_bias_s;
        end
    end

    // Registered handshake outputs; the result is captured on the BIAS to OUT edge and held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            out_data_r  <= '0;
        end else begin
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
            busy_r      <= busy_s;
            if (state_r == ST_BIAS) begin
                out_data_r <= activate(acc_bias_s);
            end
        end
    end
endmodule
